// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Show-ahead synchronous FIFO of {pc,instr} entries with flush; DEPTH must be a power of 2.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  ifu_entry_t       wr_data,
  output ifu_entry_t       head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  ifu_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wr_ptr] <= wr_data;
  end

  // Credit accounting upstream must never let a push land in a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push && !do_pop)
      assert (count < FULL);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues ROM reads under FIFO credit, buffers responses for decode.
// Optional misaligned-redirect fault under `define IFU_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            rd_en_rom,
  output logic [XLEN-1:0] address_rom,
  input  logic [31:0]     instruction,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  output logic            fetch_fault
);
  import ifu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  pc_q, tag_pc_q, redir_target;
  logic             inflight_q, pop, push;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   used;
  ifu_entry_t       wr_entry, head;

`ifdef IFU_MISALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (reset)               fault_q <= 1'b0;
    else if (redirect_valid) fault_q <= |redirect_pc[1:0];
  end

  assign fetch_fault  = fault_q;
  assign redir_target = redirect_pc;
`else
  assign fetch_fault  = 1'b0;
  assign redir_target = redirect_pc & ~XLEN'(3);
`endif

  // Slots committed = buffered + in flight, minus the entry leaving this cycle.
  assign pop       = if_valid & id_ready;
  assign used      = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign rd_en_rom = !reset && !redirect_valid && !fetch_fault && (used < (CNT_W+1)'(DEPTH));
  assign address_rom = pc_q;
  assign push      = inflight_q & !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en_rom;
      if (rd_en_rom) begin
        pc_q     <= pc_q + XLEN'(PC_STEP);
        tag_pc_q <= pc_q;
      end
      if (redirect_valid) pc_q <= redir_target;
    end
  end

  assign wr_entry.pc    = tag_pc_q;
  assign wr_entry.instr = instruction;

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .head    (head),
    .valid   (if_valid),
    .count   (fifo_count)
  );

  // Zero the head fields when empty so flushed entries never leak out.
  assign if_pc    = if_valid ? head.pc    : '0;
  assign if_instr = if_valid ? head.instr : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + random bench for instr_fetch_unit with a stream-level reference model.
`define CHK(tag, obs, exp) \
  begin \
    n_chk++; \
    assert ((obs) === (exp)) else begin \
      n_err++; \
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
  end

module tb_instr_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1, redirect_valid = 1'b0, id_ready = 1'b0;
  logic [31:0] redirect_pc = '0, instruction, address_rom, if_instr, if_pc;
  logic        rd_en_rom, if_valid, fetch_fault;

  int          n_chk = 0, n_err = 0;
  logic [31:0] exp_issue, exp_out;
  int          outstanding, since;
  bit          fault_exp, prev_rst;
  bit          done = 1'b0;

  instr_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rd_en_rom      (rd_en_rom),
    .address_rom    (address_rom),
    .instruction    (instruction),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h9E37_79B9;
  endfunction

  // Registered ROM: one-cycle read latency, zero when not selected.
  always @(posedge clk) instruction <= rd_en_rom ? rom(address_rom) : 32'h0;

  task automatic cyc(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    reset = rst; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    @(negedge clk);
    if (reset) begin
      n_chk++;
      if (rd_en_rom !== 1'b0 ||
          (prev_rst && (if_valid !== 1'b0 || if_pc !== 32'h0 ||
                        if_instr !== 32'h0 || fetch_fault !== 1'b0))) begin
        n_err++;
        $error("FAIL reset_state: rd_en=%b valid=%b pc=%0h instr=%0h fault=%b",
               rd_en_rom, if_valid, if_pc, if_instr, fetch_fault);
      end
      exp_issue = RESET_PC; exp_out = RESET_PC;
      outstanding = 0; since = 0; fault_exp = 1'b0;
    end else if (redirect_valid) begin
      `CHK("redir_noissue", rd_en_rom, 1'b0)
`ifdef IFU_MISALIGN_CHECK_EN
      tgt = redirect_pc;
      fault_exp = (redirect_pc % 4) != 0;
`else
      tgt = redirect_pc - (redirect_pc % 4);
      fault_exp = 1'b0;
`endif
      exp_issue = tgt; exp_out = tgt; outstanding = 0; since = 0;
    end else begin
      `CHK("fault_flag", fetch_fault, fault_exp)
      if (fault_exp) begin
        `CHK("fault_noissue", rd_en_rom, 1'b0)
        `CHK("fault_novalid", if_valid, 1'b0)
      end else begin
        if (since < 10) since++;
        if (since == 1) `CHK("lat_issue", rd_en_rom, 1'b1)
        if (since == 1 || since == 2) `CHK("lat_empty", if_valid, 1'b0)
        if (since == 3) `CHK("lat_first_valid", if_valid, 1'b1)
        if (if_valid) begin
          `CHK("out_pc", if_pc, exp_out)
          `CHK("out_instr", if_instr, rom(exp_out))
          if (id_ready) begin exp_out += 4; outstanding--; end
        end
        if (rd_en_rom) begin
          `CHK("issue_addr", address_rom, exp_issue)
          exp_issue += 4; outstanding++;
        end
      end
    end
    prev_rst = reset;
  endtask

  initial begin
    #200000;
    if (!done) begin
      n_err++;
      $error("FAIL timeout: stimulus did not complete in time");
      $finish;
    end
  end

  initial begin
    logic        rv, rdy;
    logic [31:0] rpc;
    prev_rst = 1'b0;
    repeat (3) cyc(1, 0, 0, 1);
    repeat (8) cyc(0, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 0);
    `CHK("stall_credit", outstanding, DEPTH)
    `CHK("stall_noissue", rd_en_rom, 1'b0)
    `CHK("stall_head_valid", if_valid, 1'b1)
    repeat (6) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h10, 0);
    repeat (6) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h40, 1);
    repeat (6) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h100, 1);
    cyc(0, 1, 32'h200, 1);
    repeat (5) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'hFFFF_FFF8, 1);
    repeat (6) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h6, 1);
    repeat (4) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h8, 1);
    repeat (6) cyc(0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      rv  = ($urandom_range(0, 99) < 4);
      rdy = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        1:       rpc = $urandom;
        default: rpc = $urandom & 32'h0000_FFFC;
      endcase
      cyc(0, rv, rpc, rdy);
    end
    cyc(1, 1, 32'h50, 1);
    cyc(1, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 1);
    done = 1'b1;
    if (n_err != 0) $error("FAIL summary: %0d miscompares", n_err);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
